sp_rom_arbiter: RTL and testbench



---
 rtl/sp_rom_arbiter.sv | 147 ++++++++++++++
 tb/tb_sp_rom_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_rom_arbiter.sv
// sp_rom_arbiter
// Round-robin arbiter sharing one synchronous single-port ROM (1-cycle
// registered read) between NUM_REQ requesters. Supports lock (burst)
// ownership so one requester can stream reads without interleaving.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester read request
//   req_lock   per-requester keep-grant, sampled with an accepted beat
//   req_addr   flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  one-hot grant (combinational, never without req_valid)
//   rsp_valid  one-hot response strobe
//   rsp_data   read data, 0 when no response
//   rom_addr   ROM address (granted requester's address, else 0)
//   rom_dout   ROM read data
//
// Optional feature macro: SP_ROM_ARB_RSP_REG_EN
//   defined   -> extra output register, response latency 2 cycles
//   undefined -> response latency 1 cycle, rsp_data muxed from rom_dout
module sp_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 36
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_dout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  tag_q;
  logic [PW-1:0]       idx, sel;
  logic                found;
  logic [DATA_WIDTH-1:0] rsp_gated;

  // Grant / next-state logic. Everything is suppressed while rst is high so
  // no beat can be accepted during reset.
  always_comb begin
    gnt     = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          // first valid requester at or after ptr, wrapping modulo NUM_REQ
          for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          if (found) begin
            gnt[sel] = 1'b1;
            ptr_d    = PW'((int'(sel) + 1) % NUM_REQ);
            if (req_lock[sel]) begin
              state_d = LOCKED;
              owner_d = sel;
            end
          end
        end
        LOCKED: begin
          // owner dropping valid releases the lock with no grant this cycle
          if (req_valid[owner_q]) begin
            gnt[owner_q] = 1'b1;
            if (!req_lock[owner_q]) begin
              state_d = ARB;
              ptr_d   = PW'((int'(owner_q) + 1) % NUM_REQ);
            end
          end else begin
            state_d = ARB;
            ptr_d   = PW'((int'(owner_q) + 1) % NUM_REQ);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign req_ready = gnt;

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rom_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // tag_q lines up with the ROM's registered read: it names the owner of
  // rom_dout in the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tag_q   <= gnt;
    end
  end

  assign rsp_gated = (|tag_q) ? rom_dout : '0;

`ifdef SP_ROM_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= tag_q;
      rsp_data_q  <= rsp_gated;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  assign rsp_valid = tag_q;
  assign rsp_data  = rsp_gated;
`endif

endmodule

// File: tb/tb_sp_rom_arbiter.sv
module tb_sp_rom_arbiter;
  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef SP_ROM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ROM model: mem[a] = 0x10 + a, 1-cycle registered read, no reset
  always @(posedge clk) rom_dout <= {4'h1, rom_addr};

  sp_rom_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_lock = '0; req_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_lock = '0; req_addr = 16'h3210;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready_in_rst got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp += 4;
      if (req_ready !== '0) begin n_bad++; $display("FAIL reset_idle_ready c=%0d got=%b want=0", c, req_ready); end
      if (rsp_valid !== '0) begin n_bad++; $display("FAIL reset_idle_rsp_valid c=%0d got=%b want=0", c, rsp_valid); end
      if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_idle_rsp_data c=%0d got=%h want=00", c, rsp_data); end
      if (rom_addr !== '0) begin n_bad++; $display("FAIL reset_idle_rom_addr c=%0d got=%h want=0", c, rom_addr); end
      @(posedge clk); #1;
    end
  endtask

  // Each directed test below: per-cycle inputs and hand-written expected
  // grant/rom_addr; the expected response is that grant LAT cycles later.
  task automatic test_single();
    logic [3:0] v[4], rdy[4], ea[4];
    logic [3:0] a0;
    logic [3:0] erv;
    logic [7:0] erd;
    a0 = (LAT == 2) ? 4'h9 : 4'h3;
    v = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    rdy = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    ea = '{a0, 4'h0, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = v[c]; req_lock = '0; req_addr = {12'h000, a0};
      @(negedge clk);
      erv = (c >= LAT) ? rdy[c-LAT] : 4'b0;
      erd = (c >= LAT && erv != 0) ? {4'h1, ea[c-LAT]} : 8'h00;
      n_cmp += 4;
      if (req_ready !== rdy[c]) begin n_bad++; $display("FAIL single_ready c=%0d got=%b want=%b", c, req_ready, rdy[c]); end
      if (rom_addr !== ea[c]) begin n_bad++; $display("FAIL single_rom_addr c=%0d got=%h want=%h", c, rom_addr, ea[c]); end
      if (rsp_valid !== erv) begin n_bad++; $display("FAIL single_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, erv); end
      if (rsp_data !== erd) begin n_bad++; $display("FAIL single_rsp_data c=%0d got=%h want=%h", c, rsp_data, erd); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy[10], ea[10];
    logic [3:0] erv;
    logic [7:0] erd;
    rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    ea  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000; req_lock = '0; req_addr = 16'h3210;
      @(negedge clk);
      erv = (c >= LAT) ? rdy[c-LAT] : 4'b0;
      erd = (c >= LAT && erv != 0) ? {4'h1, ea[c-LAT]} : 8'h00;
      n_cmp += 4;
      if (req_ready !== rdy[c]) begin n_bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, req_ready, rdy[c]); end
      if (rom_addr !== ea[c]) begin n_bad++; $display("FAIL rr_rom_addr c=%0d got=%h want=%h", c, rom_addr, ea[c]); end
      if (rsp_valid !== erv) begin n_bad++; $display("FAIL rr_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, erv); end
      if (rsp_data !== erd) begin n_bad++; $display("FAIL rr_rsp_data c=%0d got=%h want=%h", c, rsp_data, erd); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_burst();
    // c0 moves ptr to 1; c1..c3 req1 burst (addr 5,6,7) while req0/req2 wait
    logic [3:0]  v[8], lk[8], rdy[8], ea[8];
    logic [15:0] ad[8];
    logic [3:0]  erv;
    logic [7:0]  erd;
    v   = '{4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    lk  = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    ad  = '{16'h3210, 16'h3250, 16'h3260, 16'h3270, 16'h3210, 16'h3210, 16'h3210, 16'h3210};
    rdy = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    ea  = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h2, 4'h0, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = v[c]; req_lock = lk[c]; req_addr = ad[c];
      @(negedge clk);
      erv = (c >= LAT) ? rdy[c-LAT] : 4'b0;
      erd = (c >= LAT && erv != 0) ? {4'h1, ea[c-LAT]} : 8'h00;
      n_cmp += 4;
      if (req_ready !== rdy[c]) begin n_bad++; $display("FAIL lock_ready c=%0d got=%b want=%b", c, req_ready, rdy[c]); end
      if (rom_addr !== ea[c]) begin n_bad++; $display("FAIL lock_rom_addr c=%0d got=%h want=%h", c, rom_addr, ea[c]); end
      if (rsp_valid !== erv) begin n_bad++; $display("FAIL lock_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, erv); end
      if (rsp_data !== erd) begin n_bad++; $display("FAIL lock_rsp_data c=%0d got=%h want=%h", c, rsp_data, erd); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_drop();
    // req0 locks, then drops valid: no grant that cycle, then RR from 1
    logic [3:0] v[7], lk[7], rdy[7], ea[7];
    logic [3:0] erv;
    logic [7:0] erd;
    v   = '{4'b1111, 4'b1110, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
    lk  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rdy = '{4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    ea  = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = v[c]; req_lock = lk[c]; req_addr = 16'h3210;
      @(negedge clk);
      erv = (c >= LAT) ? rdy[c-LAT] : 4'b0;
      erd = (c >= LAT && erv != 0) ? {4'h1, ea[c-LAT]} : 8'h00;
      n_cmp += 4;
      if (req_ready !== rdy[c]) begin n_bad++; $display("FAIL drop_ready c=%0d got=%b want=%b", c, req_ready, rdy[c]); end
      if (rom_addr !== ea[c]) begin n_bad++; $display("FAIL drop_rom_addr c=%0d got=%h want=%h", c, rom_addr, ea[c]); end
      if (rsp_valid !== erv) begin n_bad++; $display("FAIL drop_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, erv); end
      if (rsp_data !== erd) begin n_bad++; $display("FAIL drop_rsp_data c=%0d got=%h want=%h", c, rsp_data, erd); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    // single requester (2) continuously valid, new address every beat
    logic [3:0] rdy[6], ea[6];
    logic [3:0] erv;
    logic [7:0] erd;
    rdy = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ea  = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b0100 : 4'b0000; req_lock = '0;
      req_addr = {4'h0, (c < 4) ? ea[c] : 4'h0, 8'h00};
      @(negedge clk);
      erv = (c >= LAT) ? rdy[c-LAT] : 4'b0;
      erd = (c >= LAT && erv != 0) ? {4'h1, ea[c-LAT]} : 8'h00;
      n_cmp += 4;
      if (req_ready !== rdy[c]) begin n_bad++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, req_ready, rdy[c]); end
      if (rom_addr !== ea[c]) begin n_bad++; $display("FAIL b2b_rom_addr c=%0d got=%h want=%h", c, rom_addr, ea[c]); end
      if (rsp_valid !== erv) begin n_bad++; $display("FAIL b2b_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, erv); end
      if (rsp_data !== erd) begin n_bad++; $display("FAIL b2b_rsp_data c=%0d got=%h want=%h", c, rsp_data, erd); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0001; req_addr = 16'h0003;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midrst_grant got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL midrst_ready_in_rst got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    n_cmp += 2;
    if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL midrst_rsp_valid got=%b want=0000", rsp_valid); end
    if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL midrst_rsp_data got=%h want=00", rsp_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_lock = '0; req_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_lock_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
